im_loader: RTL

- Writer side of the instruction memory: receives a byte stream, packs it into 32-bit words and writes them sequentially into a RAM-based instruction memory through a single-port write interface.
- Holds the CPU in reset while loading; releases it once the program is written.
- Sits between a byte source (UART RX or debug port) and the IM write port.

---
 rtl/im_loader.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/im_loader.sv
// -----------------------------------------------------------------------------
// im_loader -- instruction-memory loader (byte stream -> 32-bit IM writes)
//
// Receives a byte stream, packs it into little-endian 32-bit words and writes
// them sequentially into the instruction memory through a single-port write
// interface. The CPU is held in reset until a load completes successfully.
//
// Stream format: N[7:0], N[15:8], then 4*N data bytes (each word LSB first),
// then, when IM_LOADER_CHKSUM_EN is defined, one checksum byte equal to the
// XOR of every byte accepted before it (length bytes included).
//
// Optional feature macro: IM_LOADER_CHKSUM_EN (checksum byte + CHK state).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins a load from IDLE, DONE or ERR
//   in_valid   in   byte source has a byte
//   in_data    in   [7:0] byte value
//   in_ready   out  loader accepts a byte this cycle
//   im_we      out  IM write enable, one-cycle pulse per word
//   im_addr    out  [ROM_ADDR_BITS-1:0] IM word address
//   im_wdata   out  [ROM_WIDTH-1:0] IM write data
//   busy       out  load in progress
//   done       out  load completed, held until next start
//   error      out  load aborted, held until next start
//   cpu_rst_n  out  CPU reset, high only in DONE
// -----------------------------------------------------------------------------
module im_loader #(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  output logic                     im_we,
  output logic [ROM_ADDR_BITS-1:0] im_addr,
  output logic [ROM_WIDTH-1:0]     im_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_rst_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WR,
    S_DONE,
    S_ERR
`ifdef IM_LOADER_CHKSUM_EN
    , S_CHK
`endif
  } state_t;

  // Largest legal word count; the word index is one bit wider so that a
  // full-depth load (N == 2**ROM_ADDR_BITS) can be counted to completion.
  localparam logic [16:0]            DEPTH_N = 17'(1) << ROM_ADDR_BITS;
  localparam logic [ROM_ADDR_BITS:0] IDX_ONE = 1;

  // Where the stream goes once the last word (or an empty body) is done.
`ifdef IM_LOADER_CHKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t                   state_q, state_d;
  logic [15:0]              n_q, n_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [ROM_ADDR_BITS:0]   word_idx_q, word_idx_d;
  logic [ROM_WIDTH-1:0]     word_q, word_d;
  logic [ROM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [ROM_WIDTH-1:0]     wdata_q, wdata_d;
  logic                     in_ready_q, in_ready_d;
  logic                     im_we_q, busy_q, busy_d, done_q, error_q, cpu_rst_n_q;
`ifdef IM_LOADER_CHKSUM_EN
  logic [7:0]               chk_q, chk_d;
`endif

  logic accept;
  assign accept = in_valid && in_ready_q;

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    n_d        = n_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IM_LOADER_CHKSUM_EN
    chk_d      = chk_q;
    if (accept && state_q != S_CHK) chk_d = chk_q ^ in_data;
`endif

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          n_d        = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          word_d     = '0;
`ifdef IM_LOADER_CHKSUM_EN
          chk_d      = '0;
`endif
        end
      end

      S_LEN0: begin
        if (accept) begin
          n_d[7:0] = in_data;
          state_d  = S_LEN1;
        end
      end

      S_LEN1: begin
        if (accept) begin
          n_d[15:8] = in_data;
          if ({1'b0, in_data, n_q[7:0]} > DEPTH_N) state_d = S_ERR;
          else if ({in_data, n_q[7:0]} == 16'd0)   state_d = S_TAIL;
          else                                     state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (accept) begin
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            2'd3: word_d[31:24] = in_data;
            default: ;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // Present the completed word to the IM port for the WR cycle.
            addr_d  = word_idx_q[ROM_ADDR_BITS-1:0];
            wdata_d = word_d;
            state_d = S_WR;
          end
        end
      end

      S_WR: begin
        word_idx_d = word_idx_q + IDX_ONE;
        if (16'(word_idx_q + IDX_ONE) == n_q) state_d = S_TAIL;
        else                                  state_d = S_DATA;
      end

`ifdef IM_LOADER_CHKSUM_EN
      S_CHK: begin
        if (accept) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  // Registered status outputs are decoded from the next state so they line
  // up with the state they describe.
  always_comb begin
    in_ready_d = 1'b0;
    busy_d     = 1'b0;
    unique case (state_d)
      S_LEN0, S_LEN1, S_DATA: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
      S_WR: busy_d = 1'b1;
`ifdef IM_LOADER_CHKSUM_EN
      S_CHK: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      byte_idx_q  <= '0;
      word_idx_q  <= '0;
      word_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      in_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
`ifdef IM_LOADER_CHKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      state_q     <= state_d;
      n_q         <= n_d;
      byte_idx_q  <= byte_idx_d;
      word_idx_q  <= word_idx_d;
      word_q      <= word_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      in_ready_q  <= in_ready_d;
      im_we_q     <= (state_d == S_WR);
      busy_q      <= busy_d;
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERR);
      cpu_rst_n_q <= (state_d == S_DONE);
`ifdef IM_LOADER_CHKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = addr_q;
  assign im_wdata  = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule
